// File: rtl/gb_pkg.sv
// gb_pkg: shared geometry constants for the NPU global buffer storage core.
package gb_pkg;
  localparam int GB_DATA_W     = 256;
  localparam int GB_DEPTH      = 8192;
  localparam int GB_ADDR_W     = 13;
  localparam int GB_BANKS      = 8;
  localparam int GB_BANK_DEPTH = 1024;
endpackage

// File: rtl/globle_buffer_256x8192_if.sv
// globle_buffer_256x8192_if: write port A / read port B bundle for the global buffer RAM.
interface globle_buffer_256x8192_if
  import gb_pkg::*;
#(
  parameter int DATA_W = GB_DATA_W,
  parameter int ADDR_W = GB_ADDR_W
);
  logic              ena;
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [DATA_W-1:0] dina;
  logic              enb;
  logic [ADDR_W-1:0] addrb;
  logic [DATA_W-1:0] doutb;
  modport master (output ena, wea, addra, dina, enb, addrb, input doutb);
  modport slave  (input ena, wea, addra, dina, enb, addrb, output doutb);
endinterface

// File: rtl/gb_ram_bank.sv
// gb_ram_bank: simple dual-port read-first block RAM bank with registered read data.
module gb_ram_bank
  import gb_pkg::*;
#(
  parameter int DATA_W = GB_DATA_W,
  parameter int DEPTH  = GB_BANK_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              re,
  input  logic [ADDR_W-1:0] ra,
  output logic [DATA_W-1:0] rd
);
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    if (re) rd <= mem[ra];
  end
endmodule

// File: rtl/globle_buffer_256x8192.sv
// globle_buffer_256x8192: 256x8192 simple dual-port RAM built from eight 1024-deep banks.
// doutb is zeroed by reset via a valid flag so the banks themselves stay reset-free.
module globle_buffer_256x8192
  import gb_pkg::*;
#(
  parameter int DATA_W = GB_DATA_W,
  parameter int DEPTH  = GB_DEPTH,
  parameter int ADDR_W = GB_ADDR_W
) (
  input logic                       clk,
  input logic                       rst,
  globle_buffer_256x8192_if.slave   bus
);
  localparam int BANK_W = $clog2(GB_BANKS);
  localparam int ROW_W  = ADDR_W - BANK_W;
  logic [DATA_W-1:0] rd [GB_BANKS];
  logic [BANK_W-1:0] rsel;
  logic              vld;
  for (genvar b = 0; b < GB_BANKS; b++) begin : g_bank
    gb_ram_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH / GB_BANKS), .ADDR_W(ROW_W)) u_bank (
      .clk (clk),
      .we  (bus.ena && bus.wea && bus.addra[ADDR_W-1:ROW_W] == BANK_W'(b)),
      .wa  (bus.addra[ROW_W-1:0]),
      .wd  (bus.dina),
      .re  (bus.enb && bus.addrb[ADDR_W-1:ROW_W] == BANK_W'(b)),
      .ra  (bus.addrb[ROW_W-1:0]),
      .rd  (rd[b])
    );
  end
  // vld stays low after reset until the next enabled read, keeping doutb at 0 meanwhile
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsel <= '0;
      vld  <= 1'b0;
    end else if (bus.enb) begin
      rsel <= bus.addrb[ADDR_W-1:ROW_W];
      vld  <= 1'b1;
    end
  end
  assign bus.doutb = vld ? rd[rsel] : '0;
endmodule

// File: tb/tb_globle_buffer_256x8192.sv
// tb_globle_buffer_256x8192: directed self-checking bench for the global buffer RAM.
module tb_globle_buffer_256x8192;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;
  localparam logic [255:0] PAT_A5 = {32{8'hA5}};
  localparam logic [255:0] PAT_DE = {{15{16'h1234}}, 16'hDEAD};
  globle_buffer_256x8192_if bus ();
  globle_buffer_256x8192 dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [12:0] a, input logic [255:0] d);
    bus.ena = 1'b1; bus.wea = 1'b1; bus.addra = a; bus.dina = d;
    tick;
    bus.ena = 1'b0; bus.wea = 1'b0;
  endtask
  task automatic rd(input logic [12:0] a);
    bus.enb = 1'b1; bus.addrb = a;
    tick;
  endtask
  task automatic chk(input string name, input logic [255:0] exp);
    tests++;
    if (bus.doutb !== exp) begin
      fails++;
      $display("FAIL %s got %h exp %h", name, bus.doutb, exp);
    end
  endtask
  task automatic test_reset;
    rst = 1'b0; bus.enb = 1'b1; bus.addrb = '0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("reset_hold", '0);
    end
    rst = 1'b1;
    rd(13'h0000);
    chk("init_addr0", '0);
  endtask
  task automatic test_write_read;
    wr(13'h0000, PAT_A5);
    wr(13'h1FFF, PAT_DE);
    rd(13'h0000);
    chk("rd_0000", PAT_A5);
    bus.addrb = 13'h1FFF;
    #1 chk("latency_pre_edge", PAT_A5);
    tick;
    chk("rd_1fff", PAT_DE);
    rd(13'h0400);
    chk("rd_0400_zero", '0);
  endtask
  task automatic test_collision;
    wr(13'h0010, 256'h1);
    bus.ena = 1'b1; bus.wea = 1'b1; bus.addra = 13'h0010; bus.dina = 256'h2;
    rd(13'h0010);
    bus.ena = 1'b0; bus.wea = 1'b0;
    chk("collision_old", 256'h1);
    rd(13'h0010);
    chk("collision_new", 256'h2);
  endtask
  task automatic test_enables;
    bus.ena = 1'b0; bus.wea = 1'b1; bus.addra = 13'h0020; bus.dina = 256'hFF;
    tick;
    bus.ena = 1'b1; bus.wea = 1'b0;
    tick;
    bus.ena = 1'b0;
    rd(13'h0020);
    chk("write_suppressed", '0);
    rd(13'h0010);
    chk("hold_setup", 256'h2);
    bus.enb = 1'b0; bus.addrb = 13'h0000;
    tick;
    chk("hold_1", 256'h2);
    bus.addrb = 13'h1FFF;
    tick;
    chk("hold_2", 256'h2);
  endtask
  task automatic test_bank_cross;
    logic [12:0] a [4] = '{13'h03FF, 13'h0400, 13'h17FF, 13'h1800};
    for (int i = 0; i < 4; i++) wr(a[i], 256'(a[i]));
    for (int i = 0; i < 4; i++) begin
      rd(a[i]);
      chk("bank_cross", 256'(a[i]));
    end
  endtask
  task automatic test_reset_mid;
    rd(13'h0400);
    chk("pre_reset_rd", 256'h400);
    bus.addrb = 13'h17FF;
    #2 rst = 1'b0;
    #1 chk("async_reset_zero", '0);
    wr(13'h0030, 256'h77);
    chk("reset_during_wr", '0);
    #2 rst = 1'b1;
    bus.enb = 1'b0;
    tick;
    chk("post_release_idle", '0);
    rd(13'h0030);
    chk("wr_during_reset_kept", 256'h77);
    rd(13'h0000);
    chk("retain_0000", PAT_A5);
    rd(13'h1FFF);
    chk("retain_1fff", PAT_DE);
    rd(13'h1800);
    chk("retain_1800", 256'h1800);
  endtask
  initial begin
    bus.ena = 1'b0; bus.wea = 1'b0; bus.addra = '0; bus.dina = '0;
    bus.enb = 1'b0; bus.addrb = '0;
    test_reset;
    test_write_read;
    test_collision;
    test_enables;
    test_bank_cross;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
